fp_mul_scheduler: RTL and testbench

Round-robin scheduler that shares one multi-cycle FP32 multiplier between `NUM_REQ` requesters. Each requester hands over an operand pair with a valid/ready handshake. The scheduler then sequences the shared multiplier through start/done, and returns the product tagged with the requester index. It sits between the neuron/MAC lanes and the single multiplier instance, so the lanes never drive the multiplier directly.

---
 rtl/fp_mul_scheduler_pkg.sv | 21 ++
 rtl/fp_mul_scheduler_if.sv | 39 +++
 rtl/fp_mul_scheduler_rr_arbiter.sv | 32 +++
 rtl/fp_mul_scheduler.sv | 150 +++++++++++++++
 tb/tb_fp_mul_scheduler.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_mul_scheduler_pkg.sv
// Shared types and constants for the FP32 multiplier scheduler.
// Provides the scheduler state encoding, the FP32 word width and the
// quiet-NaN pattern returned when a multiply is abandoned.
package fp_mul_pkg;

   localparam int          FP32_W    = 32;
   localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_WAIT    = 2'd2,
      S_RESPOND = 2'd3
   } sched_state_t;

   // Index increment with wrap at n (round-robin pointer advance)
   function automatic int wrap_inc(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fp_mul_scheduler_if.sv
// Bundle of the requester, multiplier and response signals around the
// scheduler. The slave modport is the scheduler's view; the master modport
// is the surrounding lanes/multiplier/consumer.
interface fp_mul_scheduler_if #(
   parameter int NUM_REQ = 4
);
   import fp_mul_pkg::*;

   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid_i;
   logic [NUM_REQ*FP32_W-1:0] req_a_i;
   logic [NUM_REQ*FP32_W-1:0] req_b_i;
   logic [NUM_REQ-1:0]        req_ready_o;
   logic                      mul_start_o;
   logic [FP32_W-1:0]         mul_a_o;
   logic [FP32_W-1:0]         mul_b_o;
   logic                      mul_done_i;
   logic [FP32_W-1:0]         mul_result_i;
   logic                      rsp_valid_o;
   logic [ID_W-1:0]           rsp_id_o;
   logic [FP32_W-1:0]         rsp_data_o;
   logic                      rsp_err_o;
   logic                      rsp_ready_i;
   logic                      busy_o;

   modport slave (
      input  req_valid_i, req_a_i, req_b_i, mul_done_i, mul_result_i, rsp_ready_i,
      output req_ready_o, mul_start_o, mul_a_o, mul_b_o,
             rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o
   );

   modport master (
      output req_valid_i, req_a_i, req_b_i, mul_done_i, mul_result_i, rsp_ready_i,
      input  req_ready_o, mul_start_o, mul_a_o, mul_b_o,
             rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o
   );

endinterface

// File: rtl/fp_mul_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first valid requester at or
// above ptr_i, wrapping around. The pointer itself lives in the caller.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [ID_W-1:0]    grant_idx_o,
   output logic               grant_any_o
);

   // Search upward from the pointer and stop at the first valid requester
   always_comb begin
      int j;
      j           = 0;
      grant_o     = '0;
      grant_idx_o = '0;
      grant_any_o = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j = int'(ptr_i) + i;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!grant_any_o && valid_i[ID_W'(j)]) begin
            grant_any_o          = 1'b1;
            grant_o[ID_W'(j)]    = 1'b1;
            grant_idx_o          = ID_W'(j);
         end
      end
   end

endmodule

// File: rtl/fp_mul_scheduler.sv
// Round-robin scheduler sharing one multi-cycle FP32 multiplier between
// NUM_REQ requesters. One transaction in flight: accept, start pulse, wait
// for done, hold the tagged response until the consumer takes it.
// Optional feature macro: FP_MUL_SCHED_TIMEOUT_EN enables a WAIT watchdog
// that returns a quiet NaN with rsp_err_o set after TIMEOUT_CYCLES cycles.
module fp_mul_scheduler
   import fp_mul_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   fp_mul_scheduler_if.slave     bus
);

   localparam int ID_W = $clog2(NUM_REQ);

   sched_state_t       state_q;
   logic [ID_W-1:0]    rr_ptr_q;
   logic [ID_W-1:0]    owner_q;
   logic               mul_start_q;
   logic [FP32_W-1:0]  mul_a_q;
   logic [FP32_W-1:0]  mul_b_q;
   logic               rsp_valid_q;
   logic [ID_W-1:0]    rsp_id_q;
   logic [FP32_W-1:0]  rsp_data_q;
   logic               busy_q;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic               grant_any;
   logic [ID_W-1:0]    next_ptr;

`ifdef FP_MUL_SCHED_TIMEOUT_EN
   localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] wait_cnt_q;
   logic             rsp_err_q;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .valid_i     (bus.req_valid_i),
      .ptr_i       (rr_ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grant_idx),
      .grant_any_o (grant_any)
   );

   assign next_ptr = ID_W'(wrap_inc(int'(owner_q), NUM_REQ));

   // Grant is only visible while idle and out of reset
   always_comb begin
      bus.req_ready_o = '0;
      if (state_q == S_IDLE && !reset_i) bus.req_ready_o = grant;
   end

   assign bus.mul_start_o = mul_start_q;
   assign bus.mul_a_o     = mul_a_q;
   assign bus.mul_b_o     = mul_b_q;
   assign bus.rsp_valid_o = rsp_valid_q;
   assign bus.rsp_id_o    = rsp_id_q;
   assign bus.rsp_data_o  = rsp_data_q;
   assign bus.busy_o      = busy_q;
`ifdef FP_MUL_SCHED_TIMEOUT_EN
   assign bus.rsp_err_o   = rsp_err_q;
`else
   assign bus.rsp_err_o   = 1'b0;
`endif

   // Scheduler FSM with registered outputs; reset discards any in-flight work
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         mul_start_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         busy_q      <= 1'b0;
`ifdef FP_MUL_SCHED_TIMEOUT_EN
         wait_cnt_q  <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         mul_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (grant_any) begin
                  mul_a_q     <= bus.req_a_i[int'(grant_idx)*FP32_W +: FP32_W];
                  mul_b_q     <= bus.req_b_i[int'(grant_idx)*FP32_W +: FP32_W];
                  owner_q     <= grant_idx;
                  mul_start_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
`ifdef FP_MUL_SCHED_TIMEOUT_EN
               wait_cnt_q <= '0;
`endif
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // Done takes priority over the watchdog on the same cycle
               if (bus.mul_done_i) begin
                  rsp_data_q  <= bus.mul_result_i;
                  rsp_id_q    <= owner_q;
                  rsp_valid_q <= 1'b1;
`ifdef FP_MUL_SCHED_TIMEOUT_EN
                  rsp_err_q   <= 1'b0;
`endif
                  state_q     <= S_RESPOND;
               end
`ifdef FP_MUL_SCHED_TIMEOUT_EN
               else if (wait_cnt_q == CNT_LAST) begin
                  rsp_data_q  <= FP32_QNAN;
                  rsp_id_q    <= owner_q;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  state_q     <= S_RESPOND;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
`endif
            end
            S_RESPOND: begin
               if (bus.rsp_ready_i) begin
                  rsp_valid_q <= 1'b0;
                  rr_ptr_q    <= next_ptr;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Directed bench for fp_mul_scheduler with a 3-cycle multiplier model.
// Watchdog expectations follow FP_MUL_SCHED_TIMEOUT_EN.
module tb_fp_mul_scheduler;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   fp_mul_scheduler_if #(.NUM_REQ(4)) bus ();

   fp_mul_scheduler #(
      .NUM_REQ        (4),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Operand table: product of each pair computed by hand
   localparam logic [31:0] A0 = 32'h3FC0_0000, B0 = 32'h4000_0000, P0 = 32'h4040_0000; // 1.5*2.0=3.0
   localparam logic [31:0] A1 = 32'h4000_0000, B1 = 32'h4000_0000, P1 = 32'h4080_0000; // 2.0*2.0=4.0
   localparam logic [31:0] A2 = 32'h4040_0000, B2 = 32'h3F00_0000, P2 = 32'h3FC0_0000; // 3.0*0.5=1.5
   localparam logic [31:0] A3 = 32'hBF80_0000, B3 = 32'h4000_0000, P3 = 32'hC000_0000; // -1.0*2.0=-2.0

   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {A0, B0}: return P0;
         {A1, B1}: return P1;
         {A2, B2}: return P2;
         {A3, B3}: return P3;
         default:  return 32'h0BAD_F00D;
      endcase
   endfunction

   function automatic logic [31:0] exp_prod(input int g);
      case (g)
         0: return P0;
         1: return P1;
         2: return P2;
         default: return P3;
      endcase
   endfunction

   // Multiplier model: done three cycles after the start cycle
   logic        model_en   = 1'b1;
   logic [1:0]  model_cnt  = 2'd0;
   logic        model_done = 1'b0;
   logic [31:0] model_res  = 32'h0;
   logic        inj_done   = 1'b0;
   logic [31:0] inj_res    = 32'h0;

   always @(posedge clk) begin
      model_done <= (model_cnt == 2'd1) && model_en;
      if (model_cnt != 2'd0) model_cnt <= model_cnt - 2'd1;
      if (bus.mul_start_o) begin
         model_cnt <= 2'd2;
         model_res <= ref_mul(bus.mul_a_o, bus.mul_b_o);
      end
   end

   assign bus.mul_done_i   = model_done | inj_done;
   assign bus.mul_result_i = inj_done ? inj_res : model_res;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"}, 32'(bus.req_ready_o), 32'h0);
      check({tag, "_mul_start"}, 32'(bus.mul_start_o), 32'h0);
      check({tag, "_mul_a"},     bus.mul_a_o,          32'h0);
      check({tag, "_mul_b"},     bus.mul_b_o,          32'h0);
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid_o), 32'h0);
      check({tag, "_rsp_id"},    32'(bus.rsp_id_o),    32'h0);
      check({tag, "_rsp_data"},  bus.rsp_data_o,       32'h0);
      check({tag, "_rsp_err"},   32'(bus.rsp_err_o),   32'h0);
      check({tag, "_busy"},      32'(bus.busy_o),      32'h0);
   endtask

   // Tick until a response is presented; cycles counted from the accept cycle
   task automatic wait_rsp(input string tag, input int bound, output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!bus.rsp_valid_o && cyc < bound);
      check({tag, "_rsp_seen"}, 32'(bus.rsp_valid_o), 32'h1);
   endtask

   // Tick until some grant is shown, bounded
   task automatic wait_grant(input string tag, input int bound);
      int cyc;
      cyc = 0;
      #1;
      while (bus.req_ready_o == '0 && cyc < bound) begin
         tick();
         #1;
         cyc++;
      end
      check({tag, "_grant_seen"}, 32'(bus.req_ready_o != '0), 32'h1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int bad;

      rst             = 1'b1;
      bus.req_valid_i = '0;
      bus.req_a_i     = {A3, A2, A1, A0};
      bus.req_b_i     = {B3, B2, B1, B0};
      bus.rsp_ready_i = 1'b1;

      // Reset state, with every requester valid to show grants are blocked
      tick();
      tick();
      bus.req_valid_i = 4'hF;
      #1;
      check_reset_outputs("reset");
      bus.req_valid_i = '0;
      rst = 1'b0;
      tick();

      // Single request from requester 0
      bus.req_valid_i = 4'b0001;
      #1;
      check("t1_grant", 32'(bus.req_ready_o), 32'h1);
      tick();
      bus.req_valid_i = '0;
      check("t1_start",     32'(bus.mul_start_o), 32'h1);
      check("t1_mul_a",     bus.mul_a_o,          A0);
      check("t1_mul_b",     bus.mul_b_o,          B0);
      check("t1_busy",      32'(bus.busy_o),      32'h1);
      check("t1_ready_off", 32'(bus.req_ready_o), 32'h0);
      tick();
      check("t1_start_pulse", 32'(bus.mul_start_o), 32'h0);
      tick();
      tick();
      check("t1_no_early_rsp", 32'(bus.rsp_valid_o), 32'h0);
      tick();
      check("t1_rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
      check("t1_rsp_id",    32'(bus.rsp_id_o),    32'h0);
      check("t1_rsp_data",  bus.rsp_data_o,       P0);
      check("t1_rsp_err",   32'(bus.rsp_err_o),   32'h0);
      tick();
      check("t1_rsp_drop", 32'(bus.rsp_valid_o), 32'h0);
      check("t1_idle",     32'(bus.busy_o),      32'h0);

      // Round robin from a fresh reset, all requesters continuously valid
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.req_valid_i = 4'hF;
      for (int n = 0; n < 5; n++) begin
         wait_grant($sformatf("rr%0d", n), 10);
         check($sformatf("rr%0d_grant", n), 32'(bus.req_ready_o), 32'(4'b0001 << (n % 4)));
         wait_rsp($sformatf("rr%0d", n), 20, cyc);
         check($sformatf("rr%0d_latency", n), 32'(cyc), 32'd5);
         check($sformatf("rr%0d_id", n),   32'(bus.rsp_id_o), 32'(n % 4));
         check($sformatf("rr%0d_data", n), bus.rsp_data_o,    exp_prod(n % 4));
      end
      bus.req_valid_i = '0;
      tick();

      // Backpressure: pointer now 1, requesters 0 and 1 valid throughout
      bus.rsp_ready_i = 1'b0;
      bus.req_valid_i = 4'b0011;
      #1;
      check("bp_grant", 32'(bus.req_ready_o), 32'h2);
      wait_rsp("bp", 20, cyc);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("bp%0d_valid", i), 32'(bus.rsp_valid_o), 32'h1);
         check($sformatf("bp%0d_id", i),    32'(bus.rsp_id_o),    32'h1);
         check($sformatf("bp%0d_data", i),  bus.rsp_data_o,       P1);
         check($sformatf("bp%0d_ready", i), 32'(bus.req_ready_o), 32'h0);
         check($sformatf("bp%0d_start", i), 32'(bus.mul_start_o), 32'h0);
         if (i == 4) begin
            inj_res  = 32'hDEAD_BEEF;
            inj_done = 1'b1;
         end else begin
            inj_done = 1'b0;
         end
         tick();
      end
      bus.rsp_ready_i = 1'b1;
      tick();
      check("bp_release", 32'(bus.rsp_valid_o), 32'h0);
      #1;
      check("bp_next_grant", 32'(bus.req_ready_o), 32'h1);
      bus.req_valid_i = '0;
      tick();

      // Reset during WAIT: pointer is 2 before the reset
      bus.req_valid_i = 4'b0100;
      #1;
      check("rw_grant", 32'(bus.req_ready_o), 32'h4);
      tick();
      bus.req_valid_i = '0;
      check("rw_start", 32'(bus.mul_start_o), 32'h1);
      tick();
      rst = 1'b1;
      tick();
      check_reset_outputs("rw");
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0) bad++;
      end
      check("rw_no_late_rsp", 32'(bad), 32'h0);
      bus.req_valid_i = 4'hF;
      #1;
      check("rw_ptr_zero", 32'(bus.req_ready_o), 32'h1);
      bus.req_valid_i = '0;
      tick();

      // Multiplier never answers
      model_en = 1'b0;
      bus.req_valid_i = 4'b0001;
      #1;
      check("to_grant", 32'(bus.req_ready_o), 32'h1);
`ifdef FP_MUL_SCHED_TIMEOUT_EN
      wait_rsp("to", 40, cyc);
      bus.req_valid_i = '0;
      check("to_latency", 32'(cyc),             32'd18);
      check("to_data",    bus.rsp_data_o,       32'h7FC0_0000);
      check("to_err",     32'(bus.rsp_err_o),   32'h1);
      check("to_id",      32'(bus.rsp_id_o),    32'h0);
      tick();
      check("to_release", 32'(bus.rsp_valid_o), 32'h0);
`else
      tick();
      bus.req_valid_i = '0;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (bus.busy_o !== 1'b1 || bus.rsp_valid_o !== 1'b0) bad++;
      end
      check("to_hold", 32'(bad), 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
